// File: rtl/led_pkg.sv
// Shared mode encoding for the LED pattern engine.
package led_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_OFF      = 3'd0;
  localparam mode_t MODE_RUN_DOWN = 3'd1;
  localparam mode_t MODE_RUN_UP   = 3'd2;
  localparam mode_t MODE_BLINK    = 3'd3;
  localparam mode_t MODE_ALL_ON   = 3'd4;
  localparam mode_t MODE_BOUNCE   = 3'd5;
  localparam mode_t MODE_COUNT    = 3'd6;

endpackage

// File: rtl/led_step_timer.sv
// Free-running step divider: wraps every STEP_CYC running clocks and flags the step.
module led_step_timer #(
  parameter int STEP_CYC = 10_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic step_o,
  output logic step_tick_o
);

  localparam int CNT_W = $clog2(STEP_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Counter next state; step_o marks the edge on which the phase advances.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    step_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      if (cnt_q == CNT_W'(STEP_CYC - 1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        step_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign step_tick_o = tick_q;

endmodule

// File: rtl/led_pattern_engine.sv
// Key-selected LED pattern generator: edge-detected mode select, stepped phase,
// and LED drive registered from next-state mode/phase so it never lags mode.
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int LED_W    = 4,
  parameter int KEY_W    = 4,
  parameter int STEP_CYC = 10_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [KEY_W-1:0] key_push,
  input  logic             pause,
  output logic [LED_W-1:0] led_state,
  output logic [2:0]       mode,
  output logic             step_tick
);

  localparam int PH_W = (($clog2(LED_W) > 1) ? $clog2(LED_W) : 1) + 1;

  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] rise_s;
  mode_t            mode_q, mode_d, key_mode_s;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             dir_q, dir_d;
  logic [LED_W-1:0] count_q, count_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             change_s, run_s, step_s;

  assign rise_s   = key_push & ~key_q;
  assign change_s = |rise_s;
  assign run_s    = ~pause && (mode_q != MODE_OFF) && (mode_q <= MODE_COUNT);

  led_step_timer #(.STEP_CYC(STEP_CYC)) u_timer (
    .clk_i       (sys_clk),
    .rst_i       (sys_rst),
    .clear_i     (change_s),
    .run_i       (run_s),
    .step_o      (step_s),
    .step_tick_o (step_tick)
  );

  // Mode selection, phase stepping and pattern decode.
  always_comb begin
    key_mode_s = MODE_OFF;
    mode_d     = mode_q;
    phase_d    = phase_q;
    dir_d      = dir_q;
    count_d    = count_q;
    led_d      = '0;

    // Scan high to low so the lowest rising key is the one that sticks.
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (rise_s[i]) begin
        key_mode_s = mode_t'(i + 1);
      end else begin
        key_mode_s = key_mode_s;
      end
    end

    if (change_s) begin
      mode_d  = (mode_q == key_mode_s) ? MODE_OFF : key_mode_s;
      phase_d = '0;
      dir_d   = 1'b0;
      count_d = '0;
    end else if (step_s) begin
      count_d = count_q + LED_W'(1);
      case (mode_q)
        MODE_RUN_DOWN, MODE_RUN_UP: begin
          phase_d = (phase_q == PH_W'(LED_W - 1)) ? '0 : phase_q + PH_W'(1);
        end
        MODE_BOUNCE: begin
          // dir_q: 0 = moving up, 1 = moving down; reverse at either end.
          if (!dir_q) begin
            if (phase_q == PH_W'(LED_W - 1)) begin
              phase_d = phase_q - PH_W'(1);
              dir_d   = 1'b1;
            end else begin
              phase_d = phase_q + PH_W'(1);
            end
          end else begin
            if (phase_q == '0) begin
              phase_d = PH_W'(1);
              dir_d   = 1'b0;
            end else begin
              phase_d = phase_q - PH_W'(1);
            end
          end
        end
        default: phase_d = phase_q + PH_W'(1);
      endcase
    end else begin
      phase_d = phase_q;
    end

    case (mode_d)
      MODE_RUN_DOWN: led_d = {1'b1, {(LED_W-1){1'b0}}} >> phase_d;
      MODE_RUN_UP:   led_d = {{(LED_W-1){1'b0}}, 1'b1} << phase_d;
      MODE_BLINK:    led_d = phase_d[0] ? '0 : '1;
      MODE_ALL_ON:   led_d = '1;
      MODE_BOUNCE:   led_d = {{(LED_W-1){1'b0}}, 1'b1} << phase_d;
      MODE_COUNT:    led_d = count_d;
      default:       led_d = '0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      key_q   <= '0;
      mode_q  <= MODE_OFF;
      phase_q <= '0;
      dir_q   <= 1'b0;
      count_q <= '0;
      led_q   <= '0;
    end else begin
      key_q   <= key_push;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      count_q <= count_d;
      led_q   <= led_d;
    end
  end

  assign led_state = led_q;
  assign mode      = mode_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed plus randomized bench for led_pattern_engine against a step-count reference model.
module tb_led_pattern_engine;

  localparam int LED_W    = 4;
  localparam int KEY_W    = 6;
  localparam int STEP_CYC = 4;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b0;
  logic [KEY_W-1:0] key_push = '0;
  logic             pause = 1'b0;
  logic [LED_W-1:0] led_state;
  logic [2:0]       mode;
  logic             step_tick;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode, running clocks and completed steps since the last mode change.
  int               m_mode = 0;
  int               m_run  = 0;
  int               m_n    = 0;
  logic             m_tick = 1'b0;
  logic [KEY_W-1:0] m_prev = '0;

  always #5 sys_clk = ~sys_clk;

  led_pattern_engine #(.LED_W(LED_W), .KEY_W(KEY_W), .STEP_CYC(STEP_CYC)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_push  (key_push),
    .pause     (pause),
    .led_state (led_state),
    .mode      (mode),
    .step_tick (step_tick)
  );

  function automatic logic [LED_W-1:0] exp_led(int md, int n);
    logic [LED_W-1:0] r;
    int p;
    r = '0;
    case (md)
      1: r[LED_W-1-(n % LED_W)] = 1'b1;
      2: r[n % LED_W] = 1'b1;
      3: r = ((n % 2) == 0) ? '1 : '0;
      4: r = '1;
      5: begin
        p = n % (2*LED_W - 2);
        if (p >= LED_W) p = 2*LED_W - 2 - p;
        r[p] = 1'b1;
      end
      6: r = LED_W'(n % (1 << LED_W));
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_n = 0; m_tick = 1'b0; m_prev = '0;
  endtask

  task automatic model_edge();
    logic [KEY_W-1:0] rise;
    int i;
    rise   = key_push & ~m_prev;
    m_prev = key_push;
    m_tick = 1'b0;
    if (rise != '0) begin
      i = 0;
      while (!rise[i]) i++;
      m_mode = (m_mode == i + 1) ? 0 : i + 1;
      m_run  = 0;
      m_n    = 0;
    end else if (!pause && m_mode != 0) begin
      m_run++;
      if (m_run % STEP_CYC == 0) begin
        m_n++;
        m_tick = 1'b1;
      end
    end
  endtask

  task automatic check(string tag);
    logic [LED_W-1:0] e_led;
    logic [2:0]       e_mode;
    e_led  = exp_led(m_mode, m_n);
    e_mode = 3'(m_mode);
    vectors++;
    assert (led_state === e_led) else begin
      miscompares++;
      $error("FAIL %s led_state obs=%b exp=%b", tag, led_state, e_led);
    end
    vectors++;
    assert (mode === e_mode) else begin
      miscompares++;
      $error("FAIL %s mode obs=%0d exp=%0d", tag, mode, e_mode);
    end
    vectors++;
    assert (step_tick === m_tick) else begin
      miscompares++;
      $error("FAIL %s step_tick obs=%b exp=%b", tag, step_tick, m_tick);
    end
  endtask

  task automatic cycles(int n, string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge sys_clk);
      model_edge();
      #1;
      check(tag);
    end
  endtask

  initial begin
    #1 sys_rst = 1'b1;
    model_reset();
    #1 check("reset");
    @(negedge sys_clk);
    sys_rst = 1'b0;
    cycles(40, "idle_off");

    key_push[0] = 1'b1;
    cycles(1, "run_down_enter");
    key_push[0] = 1'b0;
    cycles(20, "run_down");

    key_push[0] = 1'b1;
    cycles(1, "run_down_exit");
    cycles(20, "held_key");
    key_push = '0;
    cycles(2, "released");

    key_push = 6'b000110;
    cycles(1, "simul_edges");
    key_push = '0;
    cycles(12, "run_up");

    key_push[4] = 1'b1;
    cycles(1, "bounce_enter");
    key_push = '0;
    cycles(14, "bounce");
    pause = 1'b1;
    cycles(10, "bounce_pause");
    pause = 1'b0;
    cycles(24, "bounce_resume");

    key_push[3] = 1'b1;
    cycles(1, "all_on_enter");
    key_push = '0;
    cycles(9, "all_on");

    key_push[2] = 1'b1;
    cycles(1, "blink_enter");
    key_push = '0;
    cycles(12, "blink");

    key_push[5] = 1'b1;
    cycles(1, "count_enter");
    key_push = '0;
    cycles(17 * STEP_CYC + 2, "count_wrap");

    pause = 1'b1;
    key_push[1] = 1'b1;
    cycles(1, "pause_key");
    key_push = '0;
    cycles(5, "pause_hold");
    pause = 1'b0;
    cycles(6, "pause_release");

    #2 sys_rst = 1'b1;
    model_reset();
    #1 check("async_reset");
    key_push[0] = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    cycles(1, "held_through_reset");
    key_push = '0;
    cycles(6, "after_reset");

    for (int r = 0; r < 800; r++) begin
      if ($urandom_range(0, 7) == 0) key_push = KEY_W'($urandom_range(0, 63));
      pause = ($urandom_range(0, 9) == 0);
      cycles(1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
